// File: rtl/hsst_pkt_fifo_if.sv
// Packet FIFO bus bundle: write side, read side, run-time thresholds and status.
// master = FIFO user, slave = the FIFO itself.
interface hsst_pkt_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  wr_last;
  logic                  wr_drop;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   rd_level;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic [ADDR_WIDTH:0]   pkt_count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output wr_data, wr_en, wr_last, wr_drop, af_thresh,
    output rd_en, ae_thresh, clr_err,
    input  full, almost_full, wr_level,
    input  rd_data, rd_last, rd_valid, empty, almost_empty, rd_level,
    input  pkt_count, overflow, underflow
  );

  modport slave (
    input  wr_data, wr_en, wr_last, wr_drop, af_thresh,
    input  rd_en, ae_thresh, clr_err,
    output full, almost_full, wr_level,
    output rd_data, rd_last, rd_valid, empty, almost_empty, rd_level,
    output pkt_count, overflow, underflow
  );
endinterface

// File: rtl/hsst_pkt_fifo.sv
// Single-clock packet FIFO ahead of the HSST transmit path: per-packet commit/drop,
// run-time almost thresholds, standard or first-word-fall-through read, sticky errors.
module hsst_pkt_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter bit          FWFT       = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  hsst_pkt_fifo_if.slave bus
);
  localparam int unsigned   PW      = ADDR_WIDTH + 1;
  localparam int unsigned   DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  // RAM word carries the last flag above the payload
  logic [DATA_WIDTH:0]   mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         cm_ptr_q, cm_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         pkt_q, pkt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dlast_q, dlast_d;
  logic                  dval_q, dval_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic [PW-1:0]         wr_level, rd_level, rd_nxt;
  logic                  full, empty;
  logic                  wr_acc, commit, pop, popped_last, ovf_ev, udf_ev;
  logic [DATA_WIDTH:0]   head_word, next_word;

  assign wr_level  = wr_ptr_q - rd_ptr_q;
  assign rd_level  = cm_ptr_q - rd_ptr_q;
  assign rd_nxt    = rd_ptr_q + ONE_P;
  assign full      = (wr_level == DEPTH_P);
  assign empty     = FWFT ? !dval_q : (rd_ptr_q == cm_ptr_q);
  assign head_word = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign next_word = mem_q[rd_nxt[ADDR_WIDTH-1:0]];

  always_comb begin
    wr_acc      = bus.wr_en && !full && !bus.wr_drop;
    commit      = wr_acc && bus.wr_last;
    ovf_ev      = bus.wr_en && full && !bus.wr_drop;
    pop         = bus.rd_en && !empty;
    udf_ev      = bus.rd_en && empty;
    popped_last = FWFT ? dlast_q : head_word[DATA_WIDTH];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pkt_d    = pkt_q;
    dout_d   = dout_q;
    dlast_d  = dlast_q;
    dval_d   = dval_q;

    // Drop wins over a same-cycle write; an oversize partial packet that alone
    // fills the RAM is discarded so the writer can never deadlock.
    if (bus.wr_drop) begin
      wr_ptr_d = cm_ptr_q;
    end else if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE_P;
      if (bus.wr_last) begin
        cm_ptr_d = wr_ptr_q + ONE_P;
      end
    end else if (ovf_ev && (rd_level == '0)) begin
      wr_ptr_d = cm_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_nxt;
    end

    unique case ({commit, pop && popped_last})
      2'b10:   pkt_d = pkt_q + ONE_P;
      2'b01:   pkt_d = pkt_q - ONE_P;
      default: pkt_d = pkt_q;
    endcase

    if (FWFT) begin
      // Output register mirrors mem[rd_ptr]; rd_ptr only moves on a user pop.
      if (!dval_q) begin
        if (rd_ptr_q != cm_ptr_q) begin
          dval_d            = 1'b1;
          {dlast_d, dout_d} = head_word;
        end
      end else if (pop) begin
        dval_d = (rd_nxt != cm_ptr_q);
        if (rd_nxt != cm_ptr_q) begin
          {dlast_d, dout_d} = next_word;
        end
      end
    end else begin
      dval_d = pop;
      if (pop) begin
        {dlast_d, dout_d} = head_word;
      end
    end
  end

  assign ovf_d = (ovf_q && !bus.clr_err) || ovf_ev;
  assign udf_d = (udf_q && !bus.clr_err) || udf_ev;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {bus.wr_last, bus.wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
      pkt_q    <= '0;
      dout_q   <= '0;
      dlast_q  <= 1'b0;
      dval_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pkt_q    <= pkt_d;
      dout_q   <= dout_d;
      dlast_q  <= dlast_d;
      dval_q   <= dval_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.full         = full;
  assign bus.almost_full  = (wr_level >= bus.af_thresh);
  assign bus.wr_level     = wr_level;
  assign bus.rd_data      = dout_q;
  assign bus.rd_last      = dlast_q;
  assign bus.rd_valid     = dval_q;
  assign bus.empty        = empty;
  assign bus.almost_empty = (rd_level <= bus.ae_thresh);
  assign bus.rd_level     = rd_level;
  assign bus.pkt_count    = pkt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule
